hamming_ctrl: RTL and testbench

- Sequencing controller for the Hamming(15,11) datapath.
- Accepts packed test commands over a valid/ready stream, one at a time. Each command is the 16-bit format {data[10:0], n[3:0], erro}.
- Drives the existing combinational calcula_hamming, injetor and corrige_hamming stages. Each stage result is registered, so every step is observable.
- Returns the corrected word with a pass/fail flag and keeps running pass/fail counters. Used as the on-board self-test engine replacing file-driven stimulus.

---
 rtl/hamming_ctrl.sv | 150 +++++++++++++++
 tb/tb_hamming_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hamming_ctrl.sv
// Self-test sequencer for the Hamming(15,11) datapath: encode, inject, correct, report.
// Each stage result is registered so every step of a command is observable.
module hamming_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [10:0]      res_data,
  output logic             res_match,
  output logic [14:0]      res_code,
  output logic             bad_cmd,
  input  logic             clear,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             busy
);

  typedef enum logic [2:0] {StIdle, StEnc, StInj, StCor, StOut} state_e;

  // Codeword bit i holds Hamming position i+1; parity at positions 1, 2, 4, 8.
  function automatic logic [14:0] calcula_hamming(input logic [10:0] d);
    logic [14:0] c;
    c        = '0;
    c[2]     = d[0];
    c[4]     = d[1];
    c[5]     = d[2];
    c[6]     = d[3];
    c[14:8]  = d[10:4];
    c[0]     = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10] ^ c[12] ^ c[14];
    c[1]     = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10] ^ c[13] ^ c[14];
    c[3]     = c[4] ^ c[5] ^ c[6] ^ c[11] ^ c[12] ^ c[13] ^ c[14];
    c[7]     = ^c[14:8];
    return c;
  endfunction

  function automatic logic [14:0] injetor(input logic [14:0] c, input logic [3:0] n,
                                          input logic e);
    logic [14:0] r;
    r = c;
    if (e && n != 4'd15) r[n] = ~r[n];
    return r;
  endfunction

  function automatic logic [10:0] corrige_hamming(input logic [14:0] c);
    logic [3:0]  s;
    logic [14:0] f;
    s = '0;
    for (int i = 0; i < 15; i++) begin
      if (c[i]) s = s ^ 4'(i + 1);
    end
    f = c;
    if (s != 4'd0) f[s - 4'd1] = ~f[s - 4'd1];
    return {f[14:8], f[6], f[5], f[4], f[2]};
  endfunction

  state_e           state_q, state_d;
  logic [10:0]      data_q;
  logic [3:0]       n_q;
  logic             err_q;
  logic             bad_q;
  logic [14:0]      code_q;
  logic [14:0]      alt_q;
  logic [10:0]      res_data_q;
  logic             res_match_q;
  logic [CNT_W-1:0] pass_q;
  logic [CNT_W-1:0] fail_q;

  logic        accept;
  logic        res_hs;
  logic        cmd_bad;
  logic [10:0] corrected;

  assign cmd_ready = (state_q == StIdle);
  assign res_valid = (state_q == StOut);
  assign busy      = (state_q != StIdle);
  assign accept    = cmd_valid && cmd_ready;
  assign res_hs    = res_valid && res_ready;
  assign cmd_bad   = cmd_data[0] && (cmd_data[4:1] == 4'd15);
  assign corrected = corrige_hamming(alt_q);

  assign res_data   = res_data_q;
  assign res_match  = res_match_q;
  assign res_code   = alt_q;
  assign bad_cmd    = bad_q;
  assign pass_count = pass_q;
  assign fail_count = fail_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (cmd_valid) state_d = StEnc;
      StEnc:   state_d = StInj;
      StInj:   state_d = StCor;
      StCor:   state_d = StOut;
      StOut:   if (res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      n_q         <= '0;
      err_q       <= 1'b0;
      bad_q       <= 1'b0;
      code_q      <= '0;
      alt_q       <= '0;
      res_data_q  <= '0;
      res_match_q <= 1'b0;
    end else begin
      if (accept) begin
        data_q <= cmd_data[15:5];
        n_q    <= cmd_data[4:1];
        err_q  <= cmd_data[0] && !cmd_bad;
        bad_q  <= cmd_bad;
      end
      if (state_q == StEnc) code_q <= calcula_hamming(data_q);
      if (state_q == StInj) alt_q <= injetor(code_q, n_q, err_q);
      if (state_q == StCor) begin
        res_data_q  <= corrected;
        res_match_q <= (corrected == data_q);
      end
    end
  end

  // Saturating counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q <= '0;
      fail_q <= '0;
    end else if (clear) begin
      pass_q <= '0;
      fail_q <= '0;
    end else if (res_hs) begin
      if (res_match_q && pass_q != '1)  pass_q <= pass_q + CNT_W'(1);
      if (!res_match_q && fail_q != '1) fail_q <= fail_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_ctrl.sv
// Directed bench for hamming_ctrl: a wide-counter and a 2-bit-counter instance share stimulus.
module tb_hamming_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [15:0] cmd_data;
  logic        res_ready;
  logic        clear;

  logic        cmd_ready, res_valid, res_match, bad_cmd, busy;
  logic [10:0] res_data;
  logic [14:0] res_code;
  logic [7:0]  pass_count, fail_count;

  logic        cmd_ready2, res_valid2, res_match2, bad_cmd2, busy2;
  logic [10:0] res_data2;
  logic [14:0] res_code2;
  logic [1:0]  pass_count2, fail_count2;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  hamming_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_match(res_match), .res_code(res_code), .bad_cmd(bad_cmd),
    .clear(clear), .pass_count(pass_count), .fail_count(fail_count), .busy(busy)
  );

  hamming_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
    .cmd_data(cmd_data), .res_valid(res_valid2), .res_ready(res_ready),
    .res_data(res_data2), .res_match(res_match2), .res_code(res_code2), .bad_cmd(bad_cmd2),
    .clear(clear), .pass_count(pass_count2), .fail_count(fail_count2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and complete its result handshake.
  task automatic run_cmd(input logic [15:0] cmd, input logic [14:0] exp_code,
                         input logic [10:0] exp_data, input logic exp_bad);
    cmd_data  = cmd;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("cmd_ready_busy", cmd_ready, 0);
    tick();
    tick();
    check("res_valid_early", res_valid, 0);
    tick();
    check("res_valid_lat", res_valid, 1);
    check("res_code", res_code, exp_code);
    check("res_data", res_data, exp_data);
    check("res_match", res_match, 1);
    check("bad_cmd", bad_cmd, exp_bad);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("res_valid_after_hs", res_valid, 0);
    check("cmd_ready_after_hs", cmd_ready, 1);
  endtask

  initial begin
    logic [14:0] code_v;
    logic [7:0]  pass_hold;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    res_ready = 1'b0;
    clear     = 1'b0;
    #12;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_pass", pass_count, 0);
    check("rst_fail", fail_count, 0);
    check("rst_busy", busy, 0);
    check("rst_res_code", res_code, 0);
    check("rst_bad", bad_cmd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_cmd(16'h0000, 15'h0000, 11'h000, 1'b0);
    check("pass_after_first", pass_count, 1);
    run_cmd({11'h7FF, 4'd0, 1'b0}, 15'h7FFF, 11'h7FF, 1'b0);
    check("pass_after_second", pass_count, 2);
    check("pass2_after_second", pass_count2, 2);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_pass", pass_count, 0);
    check("clear_pass2", pass_count2, 0);
    check("clear_keeps_idle", busy, 0);

    for (int n = 0; n < 15; n++) begin
      code_v = 15'h7FFF ^ (15'd1 << n);
      run_cmd({11'h7FF, 4'(n), 1'b1}, code_v, 11'h7FF, 1'b0);
    end
    check("sweep_pass", pass_count, 15);
    check("sweep_fail", fail_count, 0);
    check("sat_pass2", pass_count2, 3);

    run_cmd({11'h555, 4'd15, 1'b1}, 15'h552D, 11'h555, 1'b1);
    check("bad_pass", pass_count, 16);

    // Backpressure: hold the result while a second command waits on cmd_valid.
    cmd_data  = {11'h7FF, 4'd5, 1'b1};
    cmd_valid = 1'b1;
    tick();
    cmd_data = 16'h0000;
    tick();
    tick();
    tick();
    check("bp_res_valid", res_valid, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", res_valid, 1);
      check("bp_hold_code", res_code, 15'h7FDF);
      check("bp_hold_data", res_data, 11'h7FF);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_pass", pass_count, 16);
    end
    res_ready = 1'b1;
    tick();
    check("bp_one_inc", pass_count, 17);
    check("bp_cmd_ready_next", cmd_ready, 1);
    tick();
    check("bp_second_accept", busy, 1);
    cmd_valid = 1'b0;
    tick();
    tick();
    check("rr_high_no_extra", pass_count, 17);
    tick();
    check("second_res_valid", res_valid, 1);
    check("second_res_data", res_data, 11'h000);
    check("second_res_code", res_code, 15'h0000);
    tick();
    check("second_inc", pass_count, 18);
    tick();
    tick();
    check("no_extra_idle", pass_count, 18);
    res_ready = 1'b0;

    // Clear coinciding with a result handshake.
    cmd_data  = {11'h7FF, 4'd0, 1'b0};
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    tick();
    check("clr_res_valid", res_valid, 1);
    clear     = 1'b1;
    res_ready = 1'b1;
    tick();
    clear     = 1'b0;
    res_ready = 1'b0;
    check("clr_hs_pass", pass_count, 0);
    check("clr_hs_pass2", pass_count2, 0);
    check("clr_hs_idle", cmd_ready, 1);

    run_cmd({11'h555, 4'd0, 1'b0}, 15'h552D, 11'h555, 1'b0);
    check("pre_abort_pass", pass_count, 1);

    // Reset while in INJ aborts the command.
    cmd_data  = {11'h7FF, 4'd1, 1'b1};
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("inj_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_pass", pass_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pass_hold = 8'd0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_result", res_valid, 0);
    end
    check("abort_pass_after", pass_count, pass_hold);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
